dmem_resp: RTL and testbench

Data-memory responder that serves the core's M-stage memory port: address from the ALU result, store data, write enable, access size, and a read data return.
- Main storage: word-organised RAM with byte-lane stores and sign/zero-extended loads, answered combinationally in the same cycle.
- MMIO page: a console TX byte FIFO, sticky fault/status register and a 64-bit cycle counter with a coherent snapshot.
- Instantiated beside the core in the top level; closes the core's load/store interface.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_if.sv | 24 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/dmem_resp.sv | 152 +++++++++++++++
 tb/tb_dmem_resp.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the M-stage data-memory responder: access sizes,
// MMIO register offsets and STATUS bit positions.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  localparam logic [3:0] OFF_CONSOLE = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_CYCLO   = 4'h8;
  localparam logic [3:0] OFF_CYCHI   = 4'hC;

  localparam int ST_MISALIGN = 0;
  localparam int ST_OVF      = 1;
  localparam int ST_BUS      = 2;
  localparam int ST_BITS     = 3;

endpackage

// File: rtl/dmem_if.sv
// Core load/store port plus the console TX stream; master = core side.
// The responder answers loads combinationally; tx_* is a valid/ready stream.
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [2:0]  size;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        fault;

  modport master (
    output addr, wdata, we, re, size, tx_ready,
    input  rdata, tx_data, tx_valid, fault
  );

  modport slave (
    input  addr, wdata, we, re, size, tx_ready,
    output rdata, tx_data, tx_valid, fault
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push visible at head one cycle later, head read is combinational.
// Backpressure: push_rdy drops when full unless a pop fires in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   push_rdy,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, push_fire, pop_fire;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    pop_fire  = pop_rdy & ~empty;
    // When full, the slot being freed by a same-cycle pop is the one written.
    push_rdy  = ~full | pop_fire;
    push_fire = push_vld & push_rdy;
    wr_ptr_d  = push_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_fire  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    pop_vld = ~empty;
    pop_dat = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/dmem_resp.sv
// M-stage data memory: byte-lane RAM plus MMIO page (console FIFO, sticky STATUS, cycle counter).
// Loads answer combinationally in the same cycle; console stores drop (and flag) when the FIFO is full.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          TX_DEPTH  = 8
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(TX_DEPTH) + 1;
  localparam logic [32:0] RAM_BYTES = 33'(4 * MEM_WORDS);

  logic [31:0] ram_q [MEM_WORDS];

  logic [ST_BITS-1:0] status_q, status_d;
  logic [31:0]        fault_addr_q, fault_addr_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [63:0]        cycle_q, cycle_d;

  logic          access, is_store, is_load, size_ok, misalign;
  logic          in_ram, in_mmio, ram_sel, mmio_sel, bus_err, mis_evt;
  logic [AW-1:0] idx;
  logic [3:0]    off, be;
  logic [31:0]   wdat_lane, word, ram_rd, mmio_rd;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic          push_vld, push_rdy, ovf_evt, tx_empty_n;
  logic [CW-1:0] tx_count;
  logic [ST_BITS-1:0] clr, set;

  always_comb begin
    access   = bus.re | bus.we;
    is_store = bus.we;
    is_load  = bus.re & ~bus.we;
    size_ok  = 1'b1;
    misalign = 1'b0;
    case (bus.size)
      SZ_B, SZ_BU: misalign = 1'b0;
      SZ_H, SZ_HU: misalign = bus.addr[0];
      SZ_W:        misalign = |bus.addr[1:0];
      default:     size_ok  = 1'b0;
    endcase

    in_ram   = {1'b0, bus.addr} < RAM_BYTES;
    in_mmio  = (bus.addr[31:4] == MMIO_BASE[31:4]);
    ram_sel  = access & size_ok & ~misalign & in_ram;
    mmio_sel = access & size_ok & ~misalign & in_mmio & (bus.size == SZ_W);
    // Misalignment takes precedence; undefined sizes fall into the bus-error bucket.
    bus_err  = access & ~misalign & ~ram_sel & ~mmio_sel;
    mis_evt  = access & misalign;
    idx      = bus.addr[AW+1:2];
    off      = bus.addr[3:0];

    be        = 4'b0000;
    wdat_lane = bus.wdata;
    case (bus.size)
      SZ_B, SZ_BU: begin
        be        = 4'b0001 << bus.addr[1:0];
        wdat_lane = {4{bus.wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        be        = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdat_lane = {2{bus.wdata[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase

    word   = ram_q[idx];
    lane_b = word[{bus.addr[1:0], 3'b000} +: 8];
    lane_h = bus.addr[1] ? word[31:16] : word[15:0];
    case (bus.size)
      SZ_B:    ram_rd = {{24{lane_b[7]}}, lane_b};
      SZ_BU:   ram_rd = {24'b0, lane_b};
      SZ_H:    ram_rd = {{16{lane_h[15]}}, lane_h};
      SZ_HU:   ram_rd = {16'b0, lane_h};
      SZ_W:    ram_rd = word;
      default: ram_rd = 32'b0;
    endcase

    case (off)
      OFF_CONSOLE: mmio_rd = {{(32-CW){1'b0}}, tx_count};
      OFF_STATUS:  mmio_rd = {{(32-ST_BITS){1'b0}}, status_q};
      OFF_CYCLO:   mmio_rd = cycle_q[31:0];
      OFF_CYCHI:   mmio_rd = shadow_q;
      default:     mmio_rd = 32'b0;
    endcase

    bus.rdata = 32'b0;
    if (is_load && ram_sel)       bus.rdata = ram_rd;
    else if (is_load && mmio_sel) bus.rdata = mmio_rd;
  end

  always_comb begin
    push_vld = mmio_sel & is_store & (off == OFF_CONSOLE);
    ovf_evt  = push_vld & ~push_rdy;
    clr      = (mmio_sel & is_store & (off == OFF_STATUS)) ? bus.wdata[ST_BITS-1:0] : '0;
    set      = '0;
    set[ST_MISALIGN] = mis_evt;
    set[ST_OVF]      = ovf_evt;
    set[ST_BUS]      = bus_err;
    // Set wins over a same-cycle write-1-to-clear.
    status_d     = (status_q & ~clr) | set;
    fault_addr_d = mis_evt ? bus.addr : fault_addr_q;
    shadow_d     = (mmio_sel & is_load & (off == OFF_CYCLO)) ? cycle_q[63:32] : shadow_q;
    cycle_d      = cycle_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q     <= '0;
      fault_addr_q <= '0;
      shadow_q     <= '0;
      cycle_q      <= '0;
    end else begin
      status_q     <= status_d;
      fault_addr_q <= fault_addr_d;
      shadow_q     <= shadow_d;
      cycle_q      <= cycle_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_sel && is_store && be[i]) ram_q[idx][8*i +: 8] <= wdat_lane[8*i +: 8];
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (bus.wdata[7:0]),
    .push_rdy (push_rdy),
    .pop_vld  (tx_empty_n),
    .pop_rdy  (bus.tx_ready),
    .pop_dat  (bus.tx_data),
    .count    (tx_count)
  );

  assign bus.tx_valid = tx_empty_n;
  assign bus.fault    = |status_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: vector table for RAM lane/extend behaviour, hand sequences for
// misalignment, console FIFO overflow/full-bypass, cycle snapshot and mid-run reset.
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] sb_q[$];
  string       sb_name[$];
  logic [7:0]  txq[$];
  vec_t        vt[$];

  dmem_if bus ();

  dmem_resp #(
    .MEM_WORDS (1024),
    .MMIO_BASE (MB),
    .TX_DEPTH  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.re = 1'b0; bus.size = SZ_W; bus.addr = 32'h0; bus.wdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One access cycle: compare any pending expected load, then advance the console model.
  task automatic acc(input logic we, input logic re, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bus.we = we; bus.re = re; bus.size = sz; bus.addr = a; bus.wdata = wd;
    @(negedge clk);
    rd = bus.rdata;
    if (sb_q.size() > 0) chk(sb_name.pop_front(), bus.rdata, sb_q.pop_front());
    if (!reset) begin
      if (bus.tx_ready && txq.size() > 0) void'(txq.pop_front());
      if (we && a == MB && sz == SZ_W && txq.size() < 8) txq.push_back(wd[7:0]);
    end
    tick();
    idle();
  endtask

  task automatic ld(input string name, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    sb_q.push_back(exp);
    sb_name.push_back(name);
    acc(1'b0, 1'b1, sz, a, 32'h0, rd);
  endtask

  task automatic st(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    acc(1'b1, 1'b0, sz, a, wd, rd);
  endtask

  task automatic drain(input string tag);
    int n;
    n = txq.size();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_vld%0d", tag, i), bus.tx_valid, 1);
      chk($sformatf("%s_dat%0d", tag, i), bus.tx_data, txq[0]);
      tick();
      void'(txq.pop_front());
    end
    @(negedge clk);
    chk({tag, "_empty"}, bus.tx_valid, 0);
    tick();
    bus.tx_ready = 1'b0;
  endtask

  task automatic add(input logic we, input logic re, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.re = re; v.sz = sz; v.addr = a; v.wd = wd; v.exp = exp;
    vt.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, v1, v2;

    add(1, 0, SZ_W,  32'h010, 32'hDEADBEEF, 32'h0);
    add(0, 1, SZ_B,  32'h013, 32'h0,        32'hFFFFFFDE);
    add(0, 1, SZ_BU, 32'h013, 32'h0,        32'h000000DE);
    add(0, 1, SZ_H,  32'h012, 32'h0,        32'hFFFFDEAD);
    add(0, 1, SZ_HU, 32'h012, 32'h0,        32'h0000DEAD);
    add(0, 1, SZ_B,  32'h010, 32'h0,        32'hFFFFFFEF);
    add(0, 1, SZ_BU, 32'h011, 32'h0,        32'h000000BE);
    add(0, 1, SZ_H,  32'h010, 32'h0,        32'hFFFFBEEF);
    add(1, 0, SZ_B,  32'h011, 32'hAAAAAA55, 32'h0);
    add(0, 1, SZ_W,  32'h010, 32'h0,        32'hDEAD55EF);
    add(1, 0, SZ_W,  32'h014, 32'h0,        32'h0);
    add(1, 0, SZ_H,  32'h016, 32'hFFFF7FFF, 32'h0);
    add(0, 1, SZ_H,  32'h016, 32'h0,        32'h00007FFF);
    add(0, 1, SZ_W,  32'h014, 32'h0,        32'h7FFF0000);
    add(1, 0, SZ_W,  32'h020, 32'hCAFEF00D, 32'h0);
    add(1, 0, SZ_W,  32'hFFC, 32'h89ABCDEF, 32'h0);
    add(0, 1, SZ_W,  32'hFFC, 32'h0,        32'h89ABCDEF);
    add(0, 1, SZ_BU, 32'hFFF, 32'h0,        32'h00000089);
    add(0, 1, SZ_B,  32'hFFE, 32'h0,        32'hFFFFFFAB);
    add(0, 1, SZ_W,  32'h1000, 32'h0,       32'h0);
    add(1, 1, SZ_W,  32'h018, 32'h11112222, 32'h0);
    add(0, 1, SZ_W,  32'h018, 32'h0,        32'h11112222);
    add(0, 0, SZ_W,  32'h010, 32'h0,        32'h0);
    add(0, 1, SZ_W,  MB + 32'h10, 32'h0,    32'h0);

    reset = 1'b1;
    bus.tx_ready = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_cycle", dut.cycle_q, 0);
    chk("rst_fault_addr", dut.fault_addr_q, 0);
    reset = 1'b0;
    ld("rst_cyclo", SZ_W, MB + 32'h8, 32'h0);
    ld("rst_status", SZ_W, MB + 32'h4, 32'h0);
    ld("rst_count", SZ_W, MB + 32'h0, 32'h0);

    foreach (vt[i]) begin
      sb_q.push_back(vt[i].exp);
      sb_name.push_back($sformatf("vec%0d", i));
      acc(vt[i].we, vt[i].re, vt[i].sz, vt[i].addr, vt[i].wd, rd);
    end
    ld("bus_status", SZ_W, MB + 32'h4, 32'h4);
    chk("bus_fault", bus.fault, 1);
    st(SZ_W, MB + 32'h4, 32'h7);
    chk("bus_clr_fault", bus.fault, 0);

    ld("lw_mis_rdata", SZ_W, 32'h22, 32'h0);
    chk("lw_mis_fault", bus.fault, 1);
    chk("lw_mis_addr", dut.fault_addr_q, 32'h22);
    ld("lw_mis_status", SZ_W, MB + 32'h4, 32'h1);
    st(SZ_W, MB + 32'h4, 32'h1);
    chk("w1c_fault", bus.fault, 0);
    st(SZ_H, 32'h21, 32'h0000BEEF);
    ld("sh_mis_ram", SZ_W, 32'h20, 32'hCAFEF00D);
    ld("sh_mis_status", SZ_W, MB + 32'h4, 32'h1);
    chk("sh_mis_addr", dut.fault_addr_q, 32'h21);
    st(SZ_W, MB + 32'h4, 32'h7);
    acc(1'b0, 1'b0, SZ_W, 32'h23, 32'h0, rd);
    chk("idle_mis_fault", bus.fault, 0);
    ld("mmio_hu_rdata", SZ_HU, MB + 32'h4, 32'h0);
    ld("mmio_hu_status", SZ_W, MB + 32'h4, 32'h4);
    st(SZ_W, MB + 32'h4, 32'h7);

    for (int i = 0; i < 9; i++) st(SZ_W, MB, 32'h41 + i);
    chk("ovf_tx_valid", bus.tx_valid, 1);
    chk("ovf_head", bus.tx_data, 8'h41);
    ld("ovf_count", SZ_W, MB, 32'h8);
    ld("ovf_status", SZ_W, MB + 32'h4, 32'h2);
    chk("ovf_head_stable", bus.tx_data, 8'h41);
    st(SZ_W, MB + 32'h4, 32'h7);
    drain("ovf_drain");

    for (int i = 0; i < 8; i++) st(SZ_W, MB, 32'h61 + i);
    chk("byp_head", bus.tx_data, 8'h61);
    bus.tx_ready = 1'b1;
    st(SZ_W, MB, 32'h69);
    bus.tx_ready = 1'b0;
    ld("byp_count", SZ_W, MB, 32'h8);
    ld("byp_status", SZ_W, MB + 32'h4, 32'h0);
    drain("byp_drain");

    acc(1'b0, 1'b1, SZ_W, MB + 32'h8, 32'h0, v1);
    tick();
    tick();
    acc(1'b0, 1'b1, SZ_W, MB + 32'h8, 32'h0, v2);
    chk("cyc_step", v2 - v1, 32'h3);

    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    ld("cyc_lo_wrap", SZ_W, MB + 32'h8, 32'hFFFFFFFF);
    ld("cyc_hi_snap", SZ_W, MB + 32'hC, 32'h0);
    ld("cyc_lo_next", SZ_W, MB + 32'h8, 32'h1);
    ld("cyc_hi_next", SZ_W, MB + 32'hC, 32'h1);

    st(SZ_W, 32'h40, 32'h5A5A5A5A);
    for (int i = 0; i < 3; i++) st(SZ_W, MB, 32'h71 + i);
    ld("pre_rst_mis", SZ_W, 32'h22, 32'h0);
    chk("pre_rst_fault", bus.fault, 1);
    chk("pre_rst_valid", bus.tx_valid, 1);
    reset = 1'b1;
    tick();
    txq.delete();
    chk("mid_rst_valid", bus.tx_valid, 0);
    chk("mid_rst_fault", bus.fault, 0);
    chk("mid_rst_cycle", dut.cycle_q, 0);
    chk("mid_rst_faddr", dut.fault_addr_q, 0);
    reset = 1'b0;
    ld("mid_rst_cyclo", SZ_W, MB + 32'h8, 32'h0);
    ld("mid_rst_status", SZ_W, MB + 32'h4, 32'h0);
    ld("mid_rst_count", SZ_W, MB, 32'h0);
    ld("mid_rst_ram", SZ_W, 32'h40, 32'h5A5A5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
